// File: rtl/fetch_buffer_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The buffer takes the slave view; the fetch/decode side takes the master view.
interface fetch_buffer_if #(
  parameter int unsigned CPU_ADDR_BITS = 32,
  parameter int unsigned CPU_INST_BITS = 32
);
  logic                     flush;
  logic                     fetch_val0;
  logic                     fetch_val1;
  logic [CPU_ADDR_BITS-1:0] fetch_pc;
  logic [CPU_INST_BITS-1:0] fetch_inst0;
  logic [CPU_INST_BITS-1:0] fetch_inst1;
  logic                     fetch_rdy;
  logic                     decode_rdy;
  logic [CPU_ADDR_BITS-1:0] inst0_pc;
  logic [CPU_ADDR_BITS-1:0] inst1_pc;
  logic [CPU_INST_BITS-1:0] inst0;
  logic [CPU_INST_BITS-1:0] inst1;
  logic                     inst_val;

  modport master (
    output flush, fetch_val0, fetch_val1, fetch_pc, fetch_inst0, fetch_inst1, decode_rdy,
    input  fetch_rdy, inst0_pc, inst1_pc, inst0, inst1, inst_val
  );

  modport slave (
    input  flush, fetch_val0, fetch_val1, fetch_pc, fetch_inst0, fetch_inst1, decode_rdy,
    output fetch_rdy, inst0_pc, inst1_pc, inst0, inst1, inst_val
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode; accepts up to two
// instructions per cycle and presents in-order pairs, NOP-padding a lone entry.
module fetch_buffer #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned CPU_ADDR_BITS = 32,
  parameter int unsigned CPU_INST_BITS = 32
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CPU_INST_BITS-1:0] NOP     = CPU_INST_BITS'(32'h0000_0013);
  localparam logic [CNT_W-1:0]         RDY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0]         TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0]         ONE     = CNT_W'(1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CPU_ADDR_BITS-1:0] pc_mem   [DEPTH];
  logic [CPU_INST_BITS-1:0] inst_mem [DEPTH];

  logic                     fetch_rdy;
  logic                     enq;
  logic                     deq;
  logic [CNT_W-1:0]         n_enq;
  logic [CNT_W-1:0]         n_deq;
  logic [PTR_W-1:0]         head_p1;
  logic [PTR_W-1:0]         tail_p1;
  logic [CPU_ADDR_BITS-1:0] pc_plus4;

  logic                     wr0_en;
  logic                     wr1_en;
  logic [CPU_ADDR_BITS-1:0] wr0_pc;
  logic [CPU_INST_BITS-1:0] wr0_inst;

  // Acceptance looks only at the registered count, so a full buffer stays
  // closed even when decode drains it in the same cycle.
  always_comb begin
    fetch_rdy = (count_q <= RDY_MAX);
    enq       = fetch_rdy && (bus.fetch_val0 || bus.fetch_val1);
    deq       = (count_q != '0) && bus.decode_rdy;
    head_p1   = head_q + PTR_W'(1);
    tail_p1   = tail_q + PTR_W'(1);
    pc_plus4  = bus.fetch_pc + CPU_ADDR_BITS'(4);
  end

  always_comb begin
    n_enq = '0;
    if (enq) begin
      n_enq = (bus.fetch_val0 && bus.fetch_val1) ? TWO : ONE;
    end
    n_deq = '0;
    if (deq) begin
      n_deq = (count_q >= TWO) ? TWO : ONE;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + n_enq - n_deq;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A lone slot-1 instruction lands at the tail carrying its own PC.
  always_comb begin
    wr0_en   = enq && !rst && !bus.flush;
    wr1_en   = wr0_en && bus.fetch_val0 && bus.fetch_val1;
    wr0_pc   = bus.fetch_val0 ? bus.fetch_pc    : pc_plus4;
    wr0_inst = bus.fetch_val0 ? bus.fetch_inst0 : bus.fetch_inst1;
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_mem[tail_q]   <= wr0_pc;
      inst_mem[tail_q] <= wr0_inst;
    end
    if (wr1_en) begin
      pc_mem[tail_p1]   <= pc_plus4;
      inst_mem[tail_p1] <= bus.fetch_inst1;
    end
  end

  always_comb begin
    bus.fetch_rdy = fetch_rdy;
    bus.inst_val  = 1'b0;
    bus.inst0     = '0;
    bus.inst1     = '0;
    bus.inst0_pc  = '0;
    bus.inst1_pc  = '0;
    if (count_q >= TWO) begin
      bus.inst_val = 1'b1;
      bus.inst0    = inst_mem[head_q];
      bus.inst0_pc = pc_mem[head_q];
      bus.inst1    = inst_mem[head_p1];
      bus.inst1_pc = pc_mem[head_p1];
    end else if (count_q == ONE) begin
      bus.inst_val = 1'b1;
      bus.inst0    = inst_mem[head_q];
      bus.inst0_pc = pc_mem[head_q];
      bus.inst1    = NOP;
      bus.inst1_pc = pc_mem[head_q] + CPU_ADDR_BITS'(4);
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, streaming, padding, full/backpressure,
// pointer wrap and flush, with hand-computed expectations.
module tb_fetch_buffer;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned fails;

  fetch_buffer_if #(.CPU_ADDR_BITS(32), .CPU_INST_BITS(32)) bus ();

  fetch_buffer #(.DEPTH(8), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1);
    bus.fetch_val0  = v0;
    bus.fetch_val1  = v1;
    bus.fetch_pc    = pc;
    bus.fetch_inst0 = i0;
    bus.fetch_inst1 = i1;
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] pc0, input logic [31:0] i0,
                          input logic [31:0] pc1, input logic [31:0] i1);
    chk({tag, "_val"}, {31'd0, bus.inst_val}, 32'd1);
    chk({tag, "_pc0"}, bus.inst0_pc, pc0);
    chk({tag, "_i0"},  bus.inst0,    i0);
    chk({tag, "_pc1"}, bus.inst1_pc, pc1);
    chk({tag, "_i1"},  bus.inst1,    i1);
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    fails = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.decode_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'h900, 32'hAAAA0001, 32'hAAAA0002);

    // Reset held two cycles with fetch valid
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst_val",  {31'd0, bus.inst_val},  32'd0);
    chk("rst_rdy",  {31'd0, bus.fetch_rdy}, 32'd1);
    chk("rst_i0",   bus.inst0,    32'h0);
    chk("rst_i1",   bus.inst1,    32'h0);
    chk("rst_pc0",  bus.inst0_pc, 32'h0);
    chk("rst_pc1",  bus.inst1_pc, 32'h0);
    tick();
    chk("rst_empty", {31'd0, bus.inst_val}, 32'd0);

    // Streaming
    bus.decode_rdy = 1'b1;
    drive(1'b1, 1'b1, 32'h100, 32'h11111111, 32'h22222222);
    tick();
    chk_pair("str0", 32'h100, 32'h11111111, 32'h104, 32'h22222222);
    drive(1'b1, 1'b1, 32'h108, 32'h33333333, 32'h44444444);
    tick();
    chk_pair("str1", 32'h108, 32'h33333333, 32'h10C, 32'h44444444);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("str_drained", {31'd0, bus.inst_val}, 32'd0);

    // Padding, slot 0 only
    bus.decode_rdy = 1'b0;
    drive(1'b1, 1'b0, 32'h200, 32'h00500093, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk_pair("pad0", 32'h200, 32'h00500093, 32'h204, 32'h00000013);
    bus.decode_rdy = 1'b1;
    tick();
    chk("pad0_empty", {31'd0, bus.inst_val}, 32'd0);

    // Slot 1 only takes pc+4
    bus.decode_rdy = 1'b0;
    drive(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 32'h00A00113);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk_pair("pad1", 32'h404, 32'h00A00113, 32'h408, 32'h00000013);
    bus.decode_rdy = 1'b1;
    tick();
    chk("pad1_empty", {31'd0, bus.inst_val}, 32'd0);

    // Backpressure and full: four pairs fill DEPTH=8, fifth is refused
    bus.decode_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h500 + 32'(8 * k), 32'h1000 + 32'(2 * k), 32'h1001 + 32'(2 * k));
      tick();
      if (k == 2) chk("full_rdy6", {31'd0, bus.fetch_rdy}, 32'd1);
    end
    chk("full_rdy8", {31'd0, bus.fetch_rdy}, 32'd0);
    chk_pair("full_hold", 32'h500, 32'h1000, 32'h504, 32'h1001);
    drive(1'b1, 1'b1, 32'h520, 32'h1008, 32'h1009);
    tick();
    chk("full_reject_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    chk_pair("full_stable", 32'h500, 32'h1000, 32'h504, 32'h1001);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.decode_rdy = 1'b1;
    tick();
    bus.decode_rdy = 1'b0;
    chk("full_rdy_after", {31'd0, bus.fetch_rdy}, 32'd1);
    chk_pair("full_next", 32'h508, 32'h1002, 32'h50C, 32'h1003);
    bus.decode_rdy = 1'b1;
    tick();
    chk_pair("full_d1", 32'h510, 32'h1004, 32'h514, 32'h1005);
    tick();
    chk_pair("full_d2", 32'h518, 32'h1006, 32'h51C, 32'h1007);
    tick();
    chk("full_drained", {31'd0, bus.inst_val}, 32'd0);

    // Flush on an empty buffer returns pointers to entry 0
    bus.decode_rdy = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl0_val", {31'd0, bus.inst_val},  32'd0);
    chk("fl0_rdy", {31'd0, bus.fetch_rdy}, 32'd1);

    // Wrap-around: seven singles, drain six, pair straddles entries 7 and 0
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 32'h600 + 32'(4 * k), 32'h2000 + 32'(k), 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("wrap_rdy7", {31'd0, bus.fetch_rdy}, 32'd0);
    chk_pair("wrap_head", 32'h600, 32'h2000, 32'h604, 32'h2001);
    bus.decode_rdy = 1'b1;
    tick();
    tick();
    tick();
    bus.decode_rdy = 1'b0;
    chk_pair("wrap_one", 32'h618, 32'h2006, 32'h61C, 32'h00000013);
    drive(1'b1, 1'b1, 32'h300, 32'h3000, 32'h3004);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk_pair("wrap_mix", 32'h618, 32'h2006, 32'h300, 32'h3000);
    bus.decode_rdy = 1'b1;
    tick();
    chk_pair("wrap_tail", 32'h304, 32'h3004, 32'h308, 32'h00000013);
    tick();
    chk("wrap_drained", {31'd0, bus.inst_val}, 32'd0);

    // Flush mid-operation with count 5 and simultaneous enqueue/dequeue
    bus.decode_rdy = 1'b0;
    drive(1'b1, 1'b1, 32'hA00, 32'h4000, 32'h4001);
    tick();
    drive(1'b1, 1'b1, 32'hA08, 32'h4002, 32'h4003);
    tick();
    drive(1'b1, 1'b0, 32'hA10, 32'h4004, 32'h0);
    tick();
    chk("fl_rdy5", {31'd0, bus.fetch_rdy}, 32'd1);
    chk_pair("fl_pre", 32'hA00, 32'h4000, 32'hA04, 32'h4001);
    drive(1'b1, 1'b1, 32'h700, 32'h5000, 32'h5001);
    bus.decode_rdy = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.decode_rdy = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("fl_val", {31'd0, bus.inst_val},  32'd0);
    chk("fl_rdy", {31'd0, bus.fetch_rdy}, 32'd1);
    chk("fl_pc0", bus.inst0_pc, 32'h0);
    drive(1'b1, 1'b0, 32'h800, 32'h6000, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk_pair("fl_after", 32'h800, 32'h6000, 32'h804, 32'h00000013);
    bus.decode_rdy = 1'b1;
    tick();
    chk("fl_drained", {31'd0, bus.inst_val}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between fetch and decode. Accepts up to two instructions per cycle from fetch, stores them in a circular buffer, and presents them to decode as an in-order pair. Absorbs fetch/decode rate mismatch and decode backpressure. Pads a lone trailing instruction with a NOP so decode always receives full pairs.

## Interface
- DEPTH, 8, buffer capacity in instructions; power of two, ≥4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all contents (mispredict/exception redirect)
- fetch_val0  in  1  fetch slot 0 holds a valid instruction
- fetch_val1  in  1  fetch slot 1 holds a valid instruction
- fetch_pc  in  CPU_ADDR_BITS  PC of slot 0; slot 1 PC = fetch_pc + 4
- fetch_inst0  in  CPU_INST_BITS  slot 0 instruction
- fetch_inst1  in  CPU_INST_BITS  slot 1 instruction
- fetch_rdy  out  1  buffer can accept a full packet this cycle
- decode_rdy  in  1  decode accepts the presented pair
- inst0_pc, inst1_pc  out  CPU_ADDR_BITS  PCs of presented pair
- inst0, inst1  out  CPU_INST_BITS  presented instruction pair (program order)
- inst_val  out  1  pair is valid

## Operation
- Storage: DEPTH entries of {pc, inst}; head pointer, tail pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH)+1 bits, 0..DEPTH).
- fetch_rdy = (DEPTH − count) ≥ 2; derived from registered count only, never from same-cycle dequeue.
- Enqueue when fetch_rdy && (fetch_val0 || fetch_val1):
  - both valid: entry[tail] ← slot0, entry[tail+1] ← slot1, tail += 2.
  - only slot0: entry[tail] ← slot0, tail += 1.
  - only slot1: entry[tail] ← {fetch_pc+4, fetch_inst1}, tail += 1.
- Output, combinational from registered state:
  - count ≥ 2: inst0/inst0_pc ← entry[head], inst1/inst1_pc ← entry[head+1], inst_val = 1.
  - count == 1: inst0 ← entry[head]; inst1 ← 32'h0000_0013 (addi x0,x0,0), inst1_pc ← inst0_pc + 4; inst_val = 1.
  - count == 0: all outputs 0, inst_val = 0.
- Dequeue when inst_val && decode_rdy: head += min(2, count).
- count_next = count + n_enq − n_deq; enqueue and dequeue in the same cycle both take effect.
- flush or rst: head, tail, count ← 0; same-cycle enqueue and dequeue are discarded. Entry contents need no clearing.
- Pointer arithmetic wraps naturally at DEPTH; a pair may straddle entry DEPTH−1 and entry 0.

## Timing
- Reset values: fetch_rdy = 1, inst_val = 0, inst0/inst1/inst0_pc/inst1_pc = 0.
- Latency: an instruction enqueued at edge N is visible on outputs in the cycle after edge N (one-cycle fill latency); no bypass from fetch to outputs.
- Output hold: while inst_val && !decode_rdy, all outputs stable until accepted (buffer is only appended at the tail).
- Full: count = DEPTH−1 or DEPTH ⇒ fetch_rdy = 0 even if decode dequeues that cycle.
- flush in cycle N ⇒ inst_val = 0 and fetch_rdy = 1 in cycle N+1; enqueue in N+1 is accepted normally.
- rst has priority over flush; flush has priority over enqueue/dequeue.

## Test plan
- Reset: hold rst 2 cycles with fetch_val0/1 = 1 -> after release inst_val = 0, fetch_rdy = 1, count = 0; no entries written.
- Streaming: enqueue pairs (pc 0x100/0x104, 0x108/0x10C) with decode_rdy = 1 -> decode receives 0x100/0x104 then 0x108/0x10C one cycle after each enqueue, in order.
- Padding: enqueue only slot0 {0x200, 0x00500093} -> inst0 = 0x00500093, inst1 = 0x00000013, inst1_pc = 0x204, inst_val = 1; after accept count = 0.
- Backpressure/full: DEPTH = 8, decode_rdy = 0, enqueue 4 pairs -> count = 8, fetch_rdy = 0, outputs stable at first pair; raise decode_rdy for 1 cycle -> count = 6, fetch_rdy = 1 next cycle.
- Wrap-around: enqueue 7 singles, drain 6, enqueue pair 0x300/0x304 -> pair stored at entries 7 and 0; decode sees prior entry then 0x300/0x304 in order.
- Flush mid-operation: count = 5, assert flush together with fetch_val0/1 and decode_rdy -> next cycle inst_val = 0, count = 0, flushed packet not stored.
